operand_sequencer: RTL and testbench
====================================

// Module: operand_sequencer
// PURPOSE
//  Initiator for the four-operand capture interface of the (A-B)+(C-D) compute unit.
//  - Accepts one four-operand request over a valid/ready handshake.
//  - Drives capture/op/d_out to load A, B, C, D in order, then waits for the unit's valid pulse.
//  - Returns the captured result over a valid/ready response handshake.
//  - Flags a timeout, and any mismatch against an internally computed expected result.
// PARAMETERS
//  WIDTH    8   operand width; result width is WIDTH+1
//  TIMEOUT  16  max cycles spent in WAIT before declaring timeout (>=2)
// PORTS
//  clock        in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-high; clears all state and outputs
//  req_valid    in   1        request operands valid
//  req_ready    out  1        high only in IDLE
//  req_a/b/c/d  in   WIDTH    operands A,B,C,D; sampled on req_valid&&req_ready
//  capture      out  1        capture strobe to compute unit
//  op           out  2        operand select: 0=A 1=B 2=C 3=D
//  d_out        out  WIDTH    operand data to compute unit
//  cu_valid     in   1        compute-unit result valid pulse
//  cu_result    in   WIDTH+1  compute-unit result
//  rsp_valid    out  1        response valid, held until rsp_ready
//  rsp_ready    in   1        response accepted
//  rsp_result   out  WIDTH+1  latched cu_result (0 on timeout)
//  rsp_timeout  out  1        response caused by timeout
//  rsp_mismatch out  1        cu_result != expected (0 on timeout)
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  - Every output is a flop or decoded from flopped state only.
//  - Reset values: all outputs 0 except req_ready=1; state=IDLE.
//  - States:
//    - IDLE: req_ready=1. On req_valid, latch A..D, compute
//      exp=((A-B) mod 2^W)+((C-D) mod 2^W) as a W+1-bit value (bit W = carry), go to SEND with idx=0.
//    - SEND: four consecutive cycles idx=0..3.
//      - capture=1, op=idx, d_out=operand[idx]. Exactly one strobe per operand, no gaps.
//      - After idx=3, go to WAIT with tcnt=0.
//      - Outside SEND: capture=0, op=0, d_out=0.
//    - WAIT: tcnt increments each cycle.
//      - cu_valid=1: latch cu_result, set mismatch=(cu_result!=exp), timeout=0, go to RESP.
//      - Else if tcnt==TIMEOUT-1: result=0, timeout=1, mismatch=0, go to RESP.
//      - cu_valid and the last timeout cycle together: cu_valid wins.
//    - RESP: rsp_valid=1 and rsp_* stable while rsp_ready=0.
//      On rsp_ready, go to IDLE. req_ready rises the next cycle; no back-to-back bypass.
//  - cu_valid outside WAIT (IDLE, SEND, RESP) is ignored and does not alter state.
//  - Request-to-first-capture latency is 1 cycle. The first WAIT cycle follows the op=3 cycle.
//  - Timeout response: rsp_valid rises TIMEOUT cycles after WAIT is entered.
//  - Reset mid-operation: immediate return to IDLE. capture drops asynchronously,
//    latched operands and the partial response are discarded.
//  - idx and tcnt wrap is impossible by construction: idx is 2 bits, tcnt is sized to clog2(TIMEOUT).
// TESTING
//  1. A=10,B=3,C=20,D=5; model returns 9'd22 two cycles after op=3
//     -> capture strobes op 0..3 carry 10,3,20,5; rsp_result=22, mismatch=0, timeout=0.
//  2. A=0,B=1,C=0,D=1; model returns 9'h1FE
//     -> rsp_result=9'h1FE, mismatch=0 (carry bit exercised).
//  3. A=3,B=10,C=5,D=0; model returns 9'd200 (expected 254)
//     -> rsp_result=200, mismatch=1.
//  4. TIMEOUT=16, model never pulses cu_valid
//     -> rsp_valid 16 cycles after WAIT entry; timeout=1, result=0. Spurious cu_valid during SEND is ignored.
//  5. rsp_ready held low 5 cycles after rsp_valid
//     -> rsp_* stable, req_ready=0 throughout; IDLE the cycle after rsp_ready.
//  6. reset asserted during SEND idx=2
//     -> capture=0 immediately, busy=0, req_ready=1; a new request then runs cleanly from op=0.

Source files
------------

// File: rtl/operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// operand_sequencer_if
//   Bundles the three handshakes of the operand sequencer:
//     request  : req_valid/req_ready plus the four operands A..D
//     capture  : capture/op/d_out towards the (A-B)+(C-D) compute unit,
//                cu_valid/cu_result back from it
//     response : rsp_valid/rsp_ready plus result and status flags, and busy
//   modport master : the sequencer itself
//   modport slave  : the environment (request source, compute unit, response sink)
// ---------------------------------------------------------------------------
interface operand_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] req_c;
  logic [WIDTH-1:0] req_d;

  logic             capture;
  logic [1:0]       op;
  logic [WIDTH-1:0] d_out;
  logic             cu_valid;
  logic [WIDTH:0]   cu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH:0]   rsp_result;
  logic             rsp_timeout;
  logic             rsp_mismatch;
  logic             busy;

  modport master (
    input  req_valid, req_a, req_b, req_c, req_d,
    output req_ready,
    output capture, op, d_out,
    input  cu_valid, cu_result,
    output rsp_valid, rsp_result, rsp_timeout, rsp_mismatch,
    input  rsp_ready,
    output busy
  );

  modport slave (
    output req_valid, req_a, req_b, req_c, req_d,
    input  req_ready,
    input  capture, op, d_out,
    output cu_valid, cu_result,
    input  rsp_valid, rsp_result, rsp_timeout, rsp_mismatch,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer
//   Initiator for the four-operand capture interface of the (A-B)+(C-D)
//   compute unit. Takes one request, strobes A, B, C, D into the unit on four
//   consecutive cycles, waits (bounded) for the unit's result pulse and hands
//   the result back with timeout / mismatch flags.
//
// Ports
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset; clears every register
//   bus    : operand_sequencer_if.master
//            req_*      request handshake, operands sampled on valid&&ready
//            capture/op/d_out  operand strobe towards the compute unit
//            cu_valid/cu_result result pulse from the compute unit
//            rsp_*      response handshake, held until rsp_ready
//            busy       high whenever the sequencer is not idle
//
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module operand_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  operand_sequencer_if.master bus
);

  // tcnt only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits never wrap.
  localparam int                TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0]     TCNT_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_idx;
  logic [TW-1:0]    r_tcnt;
  logic [WIDTH-1:0] r_opnd [4];
  logic [WIDTH:0]   r_exp;

  logic             r_req_ready;
  logic             r_capture;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_d_out;
  logic             r_rsp_valid;
  logic [WIDTH:0]   r_rsp_result;
  logic             r_rsp_timeout;
  logic             r_rsp_mismatch;
  logic             r_busy;

  logic [1:0]       w_idx_nxt;
  logic             w_accept;

  // Each difference wraps to WIDTH bits; the sum keeps its carry in bit WIDTH.
  function automatic logic [WIDTH:0] f_expected(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] ab;
    logic [WIDTH-1:0] cd;
    ab = a - b;
    cd = c - d;
    return {1'b0, ab} + {1'b0, cd};
  endfunction

  assign w_idx_nxt = r_idx + 2'd1;
  assign w_accept  = bus.req_valid && r_req_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= 2'd0;
      r_tcnt         <= '0;
      for (int i = 0; i < 4; i++) r_opnd[i] <= '0;
      r_exp          <= '0;
      r_req_ready    <= 1'b1;
      r_capture      <= 1'b0;
      r_op           <= 2'd0;
      r_d_out        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_timeout  <= 1'b0;
      r_rsp_mismatch <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        // ---- IDLE: take a request and present operand A on the next cycle
        ST_IDLE: begin
          if (w_accept) begin
            r_opnd[0]   <= bus.req_a;
            r_opnd[1]   <= bus.req_b;
            r_opnd[2]   <= bus.req_c;
            r_opnd[3]   <= bus.req_d;
            r_exp       <= f_expected(bus.req_a, bus.req_b, bus.req_c, bus.req_d);
            r_idx       <= 2'd0;
            r_state     <= ST_SEND;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_capture   <= 1'b1;
            r_op        <= 2'd0;
            r_d_out     <= bus.req_a;
          end
        end

        // ---- SEND: one strobe per operand, back to back
        ST_SEND: begin
          if (r_idx == 2'd3) begin
            r_state   <= ST_WAIT;
            r_tcnt    <= '0;
            r_capture <= 1'b0;
            r_op      <= 2'd0;
            r_d_out   <= '0;
          end else begin
            r_idx   <= w_idx_nxt;
            r_op    <= w_idx_nxt;
            r_d_out <= r_opnd[w_idx_nxt];
          end
        end

        // ---- WAIT: result pulse has priority over the final timeout cycle
        ST_WAIT: begin
          if (bus.cu_valid) begin
            r_state        <= ST_RESP;
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= bus.cu_result;
            r_rsp_timeout  <= 1'b0;
            r_rsp_mismatch <= (bus.cu_result != r_exp);
          end else if (r_tcnt == TCNT_LAST) begin
            r_state        <= ST_RESP;
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= '0;
            r_rsp_timeout  <= 1'b1;
            r_rsp_mismatch <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end

        // ---- RESP: hold the response; req_ready returns only after the handshake
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state        <= ST_IDLE;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_timeout  <= 1'b0;
            r_rsp_mismatch <= 1'b0;
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.capture      = r_capture;
  assign bus.op           = r_op;
  assign bus.d_out        = r_d_out;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_timeout  = r_rsp_timeout;
  assign bus.rsp_mismatch = r_rsp_mismatch;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

  localparam int W   = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  operand_sequencer_if #(.WIDTH(W)) bus ();

  operand_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  typedef struct {
    logic [W-1:0] a, b, c, d;
    int           cu_lat;    // WAIT cycle index of the cu_valid pulse, <0 = never
    logic [W:0]   cu_val;    // value the compute-unit model returns
    int           rdy_wait;  // cycles rsp_ready is held low after rsp_valid
    bit           spur;      // drive cu_valid during SEND
    logic [W:0]   e_res;
    bit           e_to;
    bit           e_mm;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: (A-B) and (C-D) each wrap modulo 2^W, the sum keeps its carry.
  function automatic logic [W:0] ref_sum(input int a, input int b, input int c, input int d);
    int s;
    s = ((a - b + 256) % 256) + ((c - d + 256) % 256);
    return s[W:0];
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic [W-1:0] ops [4];
    int  w;
    bit  got;
    int  exp_w;
    ops[0] = v.a; ops[1] = v.b; ops[2] = v.c; ops[3] = v.d;

    w = 0;
    while (!bus.req_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);

    bus.req_a = v.a; bus.req_b = v.b; bus.req_c = v.c; bus.req_d = v.d;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s strobe%0d cap/op/d/busy/rdy", tag, k),
          32'({bus.capture, bus.op, bus.d_out, bus.busy, bus.req_ready}),
          32'({1'b1, k[1:0], ops[k], 1'b1, 1'b0}));
      bus.cu_valid  = v.spur;
      bus.cu_result = 9'h0AA;
      @(posedge clk); #1;
    end
    bus.cu_valid = 1'b0;
    chk({tag, " capture low in WAIT"}, 32'({bus.capture, bus.op, bus.d_out}), 32'd0);

    w = 0; got = 0;
    while (!got && w < TMO + 4) begin
      if (bus.rsp_valid) got = 1;
      else begin
        bus.cu_valid  = (w == v.cu_lat);
        bus.cu_result = v.cu_val;
        @(posedge clk); #1;
        bus.cu_valid = 1'b0;
        w++;
      end
    end
    exp_w = (v.cu_lat >= 0 && v.cu_lat < TMO) ? v.cu_lat + 1 : TMO;
    chk({tag, " rsp arrival cycle"}, got ? 32'(w) : 32'hFFFF_FFFF, 32'(exp_w));

    chk({tag, " rsp result/to/mm"},
        32'({bus.rsp_result, bus.rsp_timeout, bus.rsp_mismatch}),
        32'({v.e_res, v.e_to, v.e_mm}));

    for (int i = 0; i < v.rdy_wait; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s hold%0d vld/res/to/mm/rdy", tag, i),
          32'({bus.rsp_valid, bus.rsp_result, bus.rsp_timeout, bus.rsp_mismatch, bus.req_ready}),
          32'({1'b1, v.e_res, v.e_to, v.e_mm, 1'b0}));
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, " idle after rsp vld/busy/rdy"},
        32'({bus.rsp_valid, bus.busy, bus.req_ready}), 32'({1'b0, 1'b0, 1'b1}));
  endtask

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int   lat;

    bus.req_valid = 0; bus.req_a = 0; bus.req_b = 0; bus.req_c = 0; bus.req_d = 0;
    bus.cu_valid  = 0; bus.cu_result = 0; bus.rsp_ready = 0;

    //           a      b      c      d      lat cu_val  rdy spur e_res   to mm
    vecs[0] = '{8'd10, 8'd3,  8'd20, 8'd5,  1,  9'd22,  0,  0,   9'd22,  0, 0};
    vecs[1] = '{8'd0,  8'd1,  8'd0,  8'd1,  1,  9'h1FE, 0,  0,   9'h1FE, 0, 0};
    vecs[2] = '{8'd3,  8'd10, 8'd5,  8'd0,  1,  9'd200, 0,  0,   9'd200, 0, 1};
    vecs[3] = '{8'd1,  8'd2,  8'd3,  8'd4,  -1, 9'd0,   0,  1,   9'd0,   1, 0};
    vecs[4] = '{8'd255,8'd0,  8'd255,8'd0,  0,  9'h1FE, 5,  0,   9'h1FE, 0, 0};
    vecs[5] = '{8'd7,  8'd7,  8'd9,  8'd9,  15, 9'd5,   1,  0,   9'd5,   0, 1};
    vecs[6] = '{8'd200,8'd100,8'd50, 8'd25, 14, 9'd125, 2,  1,   9'd125, 0, 0};

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs rdy/cap/op/d/vld/busy",
        32'({bus.req_ready, bus.capture, bus.op, bus.d_out, bus.rsp_valid, bus.busy}),
        32'({1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0}));
    chk("reset rsp result/to/mm",
        32'({bus.rsp_result, bus.rsp_timeout, bus.rsp_mismatch}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // cu_valid while idle must not start anything
    bus.cu_valid = 1'b1; bus.cu_result = 9'h055;
    @(posedge clk); #1;
    bus.cu_valid = 1'b0;
    chk("idle ignores cu_valid busy/vld/rdy",
        32'({bus.busy, bus.rsp_valid, bus.req_ready}), 32'({1'b0, 1'b0, 1'b1}));

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset during SEND idx=2
    bus.req_a = 8'd11; bus.req_b = 8'd22; bus.req_c = 8'd33; bus.req_d = 8'd44;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset strobe op2", 32'({bus.capture, bus.op, bus.d_out}), 32'({1'b1, 2'd2, 8'd33}));
    rst = 1'b1;
    #1;
    chk("async reset cap/busy/rdy/vld/op/d",
        32'({bus.capture, bus.busy, bus.req_ready, bus.rsp_valid, bus.op, bus.d_out}),
        32'({1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0}));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(vecs[0], "post-reset");

    // Randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      rv.a = W'($urandom); rv.b = W'($urandom); rv.c = W'($urandom); rv.d = W'($urandom);
      lat = int'($urandom_range(0, TMO + 2));
      rv.cu_lat = lat;
      rv.cu_val = ($urandom_range(0, 3) == 0) ? (W+1)'($urandom)
                                               : ref_sum(rv.a, rv.b, rv.c, rv.d);
      rv.rdy_wait = int'($urandom_range(0, 3));
      rv.spur = bit'($urandom_range(0, 1));
      if (lat < TMO) begin
        rv.e_res = rv.cu_val;
        rv.e_to  = 1'b0;
        rv.e_mm  = (rv.cu_val != ref_sum(rv.a, rv.b, rv.c, rv.d));
      end else begin
        rv.e_res = '0;
        rv.e_to  = 1'b1;
        rv.e_mm  = 1'b0;
      end
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
